llr_demagnitude_seq_flip: RTL and testbench
===========================================

Name: llr_demagnitude_seq_flip

Overview:
- Sequential inverse of the LLR-to-magnitude stage.
- Rebuilds signed LLRs from stored magnitudes plus hard-decision signs, and applies the BCH decoder's error-correction flip mask to produce soft output.
- Accumulates per-frame parity of the corrected hard decisions, latched at frame end.
- Sits after the BCH error locator/corrector, in front of the soft-output buffer.

Parameters:
- OUTTER_NAME, "", name of the enclosing instance; printed at elaboration.
- MODULE_NAME, "llr_demagnitude_seq_flip", instance name; printed at elaboration.
- LLR_LEN, 4, full LLR width. Magnitude width LLR_MAG_LEN = LLR_LEN-1 is derived.
- PARALLELISM, 1, symbols per cycle, P >= 1. Lane i occupies bit slice i in every bus.
- FLIP_MAG, 1, magnitude written for a flipped symbol. Range 0..2^LLR_MAG_LEN-1.
- CNT_LEN, 8, width of the flip counter.

Ports:
- clk  in  1  clock
- in_ctr_Srst  in  1  synchronous active-high reset
- in_ctr_en  in  1  enable; all state holds when low
- in_ctr_init  in  1  first beat of a frame
- in_ctr_done  in  1  last beat of a frame
- in_llr_mag  in  LLR_MAG_LEN*P  magnitudes
- in_hd  in  P  hard decisions (1 = negative LLR, i.e. sign bit set)
- in_flip  in  P  decoder correction mask (1 = flip this symbol)
- out_llr  out  LLR_LEN*P  reconstructed LLRs, sign-magnitude, MSB = sign
- out_valid  out  1  out_llr valid this cycle
- out_parity  out  1  XOR of corrected hard decisions over the last completed frame
- out_frame_done  out  1  one-cycle pulse: out_parity (and out_flip_cnt) updated
- out_flip_cnt  out  CNT_LEN  flipped-symbol count of last frame (feature only)

Behaviour:
- Reset: when in_ctr_Srst=1 at a clk edge, all outputs and internal registers become 0. Reset takes priority over all other inputs, including mid-frame; the frame in progress is discarded and nothing is latched.
- Per lane, corrected sign s = in_hd[i] ^ in_flip[i].
  - in_flip[i]=0: out_llr lane = {s, in_llr_mag lane}.
  - in_flip[i]=1: out_llr lane = {s, FLIP_MAG[LLR_MAG_LEN-1:0]}.
- Latency: 1 cycle, registered output. out_valid at edge k+1 equals in_ctr_en at edge k. With en=0, out_llr holds its value and out_valid=0.
- Beats with en=1 and no open frame (no init seen since the last done/reset): out_llr is still produced, but the beat does not enter the accumulators.
- Frame states:
  - IDLE: on en & init, go to ACTIVE (or straight back to IDLE if done is also set).
  - ACTIVE: on en & done, go to IDLE. en & init while ACTIVE restarts the frame; the previous partial frame is dropped with no latch.
- Parity accumulator acc:
  - on en & init: acc <= XOR of all lane s (init beat data counts);
  - else in ACTIVE with en: acc <= acc ^ XOR(lane s).
- Frame end, on en & done in ACTIVE, or en & init & done together (single-beat frame): out_parity <= final acc including the done-beat data. out_frame_done pulses 1 for exactly one cycle. Otherwise out_frame_done=0 and out_parity holds.
- done without an open frame: ignored, no pulse.

Optional Feature:
- Macro LLR_DEMAG_FLIP_CNT_EN.
- Defined: a CNT_LEN-bit counter accumulates the popcount of in_flip over frame beats, using the same init/done/restart rules as the parity accumulator. The counter saturates at 2^CNT_LEN-1 with no wrap. It is latched to out_flip_cnt with the out_frame_done pulse and reset to 0.
- Undefined: no counter logic; out_flip_cnt is tied to 0.

Test Plan:
- Reset mid-frame: P=1, init, 2 beats, then Srst -> all outputs 0. A subsequent done produces no out_frame_done pulse.
- Passthrough: P=1, mag=5, hd=1, flip=0, en=1 -> out_llr=4'b1101 next cycle, out_valid=1. Then en=0 -> out_llr holds 4'b1101, out_valid=0.
- Flip: mag=6, hd=0, flip=1, FLIP_MAG=1 -> out_llr=4'b1001.
- Frame parity: P=2, 3-beat frame, corrected signs {1,0},{1,1},{0,1} -> out_parity=0 with a single out_frame_done pulse 1 cycle after done. Repeat with the last beat's signs changed to {0,0} -> out_parity=1.
- Single-beat frame and restart:
  - init & done together with corrected signs {1,0} -> out_parity=1, pulse.
  - init, 1 beat, init again, done -> parity covers only the second frame.
- Feature on: CNT_LEN=2, a frame with 5 flips -> out_flip_cnt=3 (saturated). Feature off -> out_flip_cnt=0.

Source files
------------

// File: rtl/llr_demagnitude_seq_flip_if.sv
// Bus bundle for llr_demagnitude_seq_flip: frame control, per-lane magnitudes,
// hard decisions and flip mask in; rebuilt LLRs and per-frame status out.
interface llr_demagnitude_seq_flip_if #(
  parameter int LLR_LEN     = 4,
  parameter int PARALLELISM = 1,
  parameter int CNT_LEN     = 8
);
  localparam int LLR_MAG_LEN = LLR_LEN - 1;

  logic                               in_ctr_en;
  logic                               in_ctr_init;
  logic                               in_ctr_done;
  logic [LLR_MAG_LEN*PARALLELISM-1:0] in_llr_mag;
  logic [PARALLELISM-1:0]             in_hd;
  logic [PARALLELISM-1:0]             in_flip;
  logic [LLR_LEN*PARALLELISM-1:0]     out_llr;
  logic                               out_valid;
  logic                               out_parity;
  logic                               out_frame_done;
  logic [CNT_LEN-1:0]                 out_flip_cnt;

  modport master (
    output in_ctr_en, in_ctr_init, in_ctr_done, in_llr_mag, in_hd, in_flip,
    input  out_llr, out_valid, out_parity, out_frame_done, out_flip_cnt
  );

  modport slave (
    input  in_ctr_en, in_ctr_init, in_ctr_done, in_llr_mag, in_hd, in_flip,
    output out_llr, out_valid, out_parity, out_frame_done, out_flip_cnt
  );
endinterface

// File: rtl/llr_demagnitude_seq_flip.sv
// Rebuilds sign-magnitude LLRs from magnitudes + corrected hard decisions and
// tracks per-frame parity. Optional flip counter: define LLR_DEMAG_FLIP_CNT_EN.
module llr_demagnitude_seq_flip #(
  parameter     OUTTER_NAME = "",
  parameter     MODULE_NAME = "llr_demagnitude_seq_flip",
  parameter int LLR_LEN     = 4,
  parameter int PARALLELISM = 1,
  parameter int FLIP_MAG    = 1,
  parameter int CNT_LEN     = 8
) (
  input  logic                         clk,
  input  logic                         in_ctr_Srst,
  llr_demagnitude_seq_flip_if.slave    bus
);
  localparam int LLR_MAG_LEN = LLR_LEN - 1;
  localparam logic [LLR_MAG_LEN-1:0] FLIP_MAG_V = LLR_MAG_LEN'(FLIP_MAG);

  if (LLR_LEN < 2 || PARALLELISM < 1 || CNT_LEN < 1) begin : g_param_chk
    $error("%s.%s: invalid LLR_LEN/PARALLELISM/CNT_LEN", OUTTER_NAME, MODULE_NAME);
  end

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                         state_q, state_d;
  logic                           acc_q, acc_d;
  logic [LLR_LEN*PARALLELISM-1:0] llr_q, llr_d;
  logic                           valid_q, valid_d;
  logic                           parity_q, parity_d;
  logic                           frame_done_q, frame_done_d;

  logic [PARALLELISM-1:0]         sgn;
  logic                           beat_x;
  logic [LLR_LEN*PARALLELISM-1:0] rebuilt;
  logic                           frame_start, frame_cont, frame_end;

  always_comb begin
    sgn     = bus.in_hd ^ bus.in_flip;
    beat_x  = ^sgn;
    rebuilt = '0;
    for (int unsigned i = 0; i < PARALLELISM; i++) begin
      rebuilt[i*LLR_LEN +: LLR_LEN] =
        {sgn[i], bus.in_flip[i] ? FLIP_MAG_V : bus.in_llr_mag[i*LLR_MAG_LEN +: LLR_MAG_LEN]};
    end
  end

  // init always (re)opens a frame; done closes it only if one is open or opening
  assign frame_start = bus.in_ctr_en & bus.in_ctr_init;
  assign frame_cont  = bus.in_ctr_en & ~bus.in_ctr_init & (state_q == ST_ACTIVE);
  assign frame_end   = bus.in_ctr_en & bus.in_ctr_done &
                       (bus.in_ctr_init | (state_q == ST_ACTIVE));

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    llr_d        = llr_q;
    valid_d      = bus.in_ctr_en;
    parity_d     = parity_q;
    frame_done_d = 1'b0;
    if (bus.in_ctr_en) llr_d = rebuilt;
    if (frame_start) begin
      acc_d   = beat_x;
      state_d = ST_ACTIVE;
    end else if (frame_cont) begin
      acc_d = acc_q ^ beat_x;
    end
    if (frame_end) begin
      parity_d     = acc_d;
      frame_done_d = 1'b1;
      state_d      = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ctr_Srst) begin
      state_q      <= ST_IDLE;
      acc_q        <= 1'b0;
      llr_q        <= '0;
      valid_q      <= 1'b0;
      parity_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      llr_q        <= llr_d;
      valid_q      <= valid_d;
      parity_q     <= parity_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.out_llr        = llr_q;
  assign bus.out_valid      = valid_q;
  assign bus.out_parity     = parity_q;
  assign bus.out_frame_done = frame_done_q;

`ifdef LLR_DEMAG_FLIP_CNT_EN
  localparam int PC_W  = $clog2(PARALLELISM + 1);
  localparam int SUM_W = ((CNT_LEN > PC_W) ? CNT_LEN : PC_W) + 1;

  logic [CNT_LEN-1:0] cnt_q, cnt_d, flip_cnt_q, flip_cnt_d;
  logic [CNT_LEN-1:0] cnt_base, cnt_next;
  logic [PC_W-1:0]    pop;
  logic [SUM_W-1:0]   sum;

  // Saturating add of this beat's flip popcount onto the running count
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < PARALLELISM; i++) begin
      pop = pop + PC_W'(bus.in_flip[i]);
    end
    cnt_base = frame_start ? '0 : cnt_q;
    sum      = SUM_W'(cnt_base) + SUM_W'(pop);
    cnt_next = (sum > SUM_W'({CNT_LEN{1'b1}})) ? '1 : sum[CNT_LEN-1:0];

    cnt_d      = cnt_q;
    flip_cnt_d = flip_cnt_q;
    if (frame_start || frame_cont) cnt_d = cnt_next;
    if (frame_end) begin
      flip_cnt_d = cnt_next;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ctr_Srst) begin
      cnt_q      <= '0;
      flip_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      flip_cnt_q <= flip_cnt_d;
    end
  end

  assign bus.out_flip_cnt = flip_cnt_q;
`else
  assign bus.out_flip_cnt = {CNT_LEN{1'b0}};
`endif
endmodule

// File: tb/tb_llr_demagnitude_seq_flip.sv
// Directed-vector bench: a P=1 instance for LLR rebuild/reset, a P=2 instance
// (CNT_LEN=2) for frame parity, restart and flip-count saturation.
module tb_llr_demagnitude_seq_flip;
  logic clk;
  logic rst;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

`ifdef LLR_DEMAG_FLIP_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  llr_demagnitude_seq_flip_if #(.LLR_LEN(4), .PARALLELISM(1), .CNT_LEN(8)) b1 ();
  llr_demagnitude_seq_flip_if #(.LLR_LEN(4), .PARALLELISM(2), .CNT_LEN(2)) b2 ();

  llr_demagnitude_seq_flip #(
    .OUTTER_NAME("tb"), .MODULE_NAME("dut1"),
    .LLR_LEN(4), .PARALLELISM(1), .FLIP_MAG(1), .CNT_LEN(8)
  ) dut1 (.clk(clk), .in_ctr_Srst(rst), .bus(b1.slave));

  llr_demagnitude_seq_flip #(
    .OUTTER_NAME("tb"), .MODULE_NAME("dut2"),
    .LLR_LEN(4), .PARALLELISM(2), .FLIP_MAG(1), .CNT_LEN(2)
  ) dut2 (.clk(clk), .in_ctr_Srst(rst), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one beat, clock it in, then settle past the edge for sampling
  task automatic drv1(input logic en, input logic init, input logic done,
                      input logic [2:0] mag, input logic hd, input logic flip);
    b1.in_ctr_en   = en;
    b1.in_ctr_init = init;
    b1.in_ctr_done = done;
    b1.in_llr_mag  = mag;
    b1.in_hd       = hd;
    b1.in_flip     = flip;
    @(posedge clk);
    #1;
  endtask

  task automatic drv2(input logic en, input logic init, input logic done,
                      input logic [5:0] mag, input logic [1:0] hd, input logic [1:0] flip);
    b2.in_ctr_en   = en;
    b2.in_ctr_init = init;
    b2.in_ctr_done = done;
    b2.in_llr_mag  = mag;
    b2.in_hd       = hd;
    b2.in_flip     = flip;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    b1.in_ctr_en = 1'b0; b1.in_ctr_init = 1'b0; b1.in_ctr_done = 1'b0;
    b1.in_llr_mag = '0;  b1.in_hd = '0;         b1.in_flip = '0;
    b2.in_ctr_en = 1'b0; b2.in_ctr_init = 1'b0; b2.in_ctr_done = 1'b0;
    b2.in_llr_mag = '0;  b2.in_hd = '0;         b2.in_flip = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_llr1",   b1.out_llr, 0);
    chk("rst_valid1", b1.out_valid, 0);
    chk("rst_llr2",   b2.out_llr, 0);
    chk("rst_par2",   b2.out_parity, 0);
    chk("rst_fd2",    b2.out_frame_done, 0);
    chk("rst_cnt2",   b2.out_flip_cnt, 0);
    rst = 1'b0;

    // P=1: single-beat frame sets parity, then a reset mid-frame clears everything
    drv1(1, 1, 1, 3'd0, 1, 0);
    chk("sb1_llr", b1.out_llr, 4'b1000);
    chk("sb1_par", b1.out_parity, 1);
    chk("sb1_fd",  b1.out_frame_done, 1);
    drv1(1, 1, 0, 3'd3, 0, 0);
    drv1(1, 0, 0, 3'd2, 0, 0);
    rst = 1'b1;
    drv1(1, 0, 0, 3'd7, 1, 0);
    chk("mrst_llr",   b1.out_llr, 0);
    chk("mrst_valid", b1.out_valid, 0);
    chk("mrst_par",   b1.out_parity, 0);
    chk("mrst_fd",    b1.out_frame_done, 0);
    rst = 1'b0;
    drv1(1, 0, 1, 3'd4, 0, 0);
    chk("orphan_done_fd",  b1.out_frame_done, 0);
    chk("orphan_done_par", b1.out_parity, 0);
    chk("orphan_llr",      b1.out_llr, 4'b0100);

    // Passthrough, hold with en=0, flip substitution
    drv1(1, 0, 0, 3'd5, 1, 0);
    chk("pass_llr",   b1.out_llr, 4'b1101);
    chk("pass_valid", b1.out_valid, 1);
    drv1(0, 0, 0, 3'd2, 0, 1);
    chk("hold_llr",   b1.out_llr, 4'b1101);
    chk("hold_valid", b1.out_valid, 0);
    drv1(1, 0, 0, 3'd6, 0, 1);
    chk("flip_llr", b1.out_llr, 4'b1001);
    drv1(1, 0, 0, 3'd6, 1, 1);
    chk("flip_neg_llr", b1.out_llr, 4'b0001);
    drv1(0, 0, 0, 3'd0, 0, 0);

    // P=2 frame A: signs {1,0},{1,1},{0,1}, flips 2+0+1
    drv2(1, 1, 0, 6'o75, 2'b01, 2'b11);
    chk("fa_b1_llr", b2.out_llr, 8'h91);
    chk("fa_b1_fd",  b2.out_frame_done, 0);
    drv2(1, 0, 0, 6'o34, 2'b11, 2'b00);
    chk("fa_b2_llr", b2.out_llr, 8'hBC);
    drv2(1, 0, 1, 6'o00, 2'b00, 2'b01);
    chk("fa_par", b2.out_parity, 0);
    chk("fa_fd",  b2.out_frame_done, 1);
    chk("fa_cnt", b2.out_flip_cnt, CNT_ON ? 3 : 0);
    drv2(0, 0, 0, 6'o00, 2'b00, 2'b00);
    chk("fa_fd_pulse", b2.out_frame_done, 0);
    chk("fa_par_hold", b2.out_parity, 0);

    // Frame B: last beat signs {0,0}, flips 2+0+0
    drv2(1, 1, 0, 6'o00, 2'b01, 2'b11);
    drv2(1, 0, 0, 6'o00, 2'b11, 2'b00);
    drv2(1, 0, 1, 6'o00, 2'b00, 2'b00);
    chk("fb_par", b2.out_parity, 1);
    chk("fb_fd",  b2.out_frame_done, 1);
    chk("fb_cnt", b2.out_flip_cnt, CNT_ON ? 2 : 0);

    // Out-of-frame beat is not accumulated; single-beat frame with signs {0,0}
    drv2(1, 0, 0, 6'o00, 2'b01, 2'b00);
    drv2(1, 1, 1, 6'o00, 2'b00, 2'b00);
    chk("sbz_par", b2.out_parity, 0);
    chk("sbz_fd",  b2.out_frame_done, 1);

    // Single-beat frame with signs {1,0}
    drv2(1, 1, 1, 6'o00, 2'b10, 2'b00);
    chk("sb_par", b2.out_parity, 1);
    chk("sb_fd",  b2.out_frame_done, 1);
    chk("sb_cnt", b2.out_flip_cnt, 0);

    // Restart: partial frame (signs 01,00; 4 flips) dropped, then 11,10 with 1 flip
    drv2(1, 1, 0, 6'o00, 2'b10, 2'b11);
    drv2(1, 0, 0, 6'o00, 2'b11, 2'b11);
    drv2(1, 1, 0, 6'o00, 2'b10, 2'b01);
    chk("rs_init_fd", b2.out_frame_done, 0);
    drv2(1, 0, 1, 6'o00, 2'b10, 2'b00);
    chk("rs_par", b2.out_parity, 1);
    chk("rs_fd",  b2.out_frame_done, 1);
    chk("rs_cnt", b2.out_flip_cnt, CNT_ON ? 1 : 0);

    // Saturation: 2+2+1 flips into a 2-bit counter; signs 11,11,01
    drv2(1, 1, 0, 6'o00, 2'b00, 2'b11);
    drv2(1, 0, 0, 6'o00, 2'b00, 2'b11);
    drv2(1, 0, 1, 6'o00, 2'b00, 2'b01);
    chk("sat_cnt", b2.out_flip_cnt, CNT_ON ? 3 : 0);
    chk("sat_par", b2.out_parity, 1);

    // done with no open frame: no pulse, parity holds
    drv2(1, 0, 1, 6'o00, 2'b00, 2'b00);
    chk("idle_done_fd",  b2.out_frame_done, 0);
    chk("idle_done_par", b2.out_parity, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
